// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : stall/flush controller for the 5-stage pipeline (IF ID EX MEM WB)
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       acki_n,
  input  logic       ackd_n,
  input  logic       mem_req,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_redirect,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_we,
  output logic       idex_flush,
  output logic       exmem_we,
  output logic       memwb_we,
  output logic       memwb_flush,
  output logic       dwait,
  output logic       bus_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_dstall,
  output logic [31:0] perf_lu,
  output logic [31:0] perf_flush
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  logic dstall;
  logic load_use;
  logic lu_event;
  logic redir_event;

  assign dstall   = mem_req & ~ackd_n;
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    case (state_q)
      RUN: begin
        if (dstall) begin
          state_d = DWAIT;
          cnt_d   = CNT_ONE;
        end
      end
      DWAIT: begin
        // Dropped request and completed access both leave the wait cleanly.
        if (!mem_req || ackd_n) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q >= TIMEOUT_VAL) begin
          state_d   = ERR;
          bus_err_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ERR:     bus_err_d = 1'b1;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_flush  = 1'b0;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    memwb_flush = 1'b0;
    lu_event    = 1'b0;
    redir_event = 1'b0;
    if (!rst) begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
      {ifid_flush, idex_flush, memwb_flush}         = '1;
    end else if (state_q == ERR) begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
    end else if (dstall) begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
      memwb_flush = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      redir_event = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID; ID/EX still loads so the bubble lands there.
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
      lu_event   = 1'b1;
    end else if (!acki_n) begin
      pc_we      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  assign dwait   = (state_q == DWAIT);
  assign bus_err = bus_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_dstall_q, perf_dstall_d;
  logic [31:0] perf_lu_q, perf_lu_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_dstall_d = perf_dstall_q;
    perf_lu_d     = perf_lu_q;
    perf_flush_d  = perf_flush_q;
    if (dstall && (state_q != ERR) && (perf_dstall_q != 32'hFFFF_FFFF))
      perf_dstall_d = perf_dstall_q + 32'd1;
    if (lu_event && (perf_lu_q != 32'hFFFF_FFFF))
      perf_lu_d = perf_lu_q + 32'd1;
    if (redir_event && (perf_flush_q != 32'hFFFF_FFFF))
      perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_dstall_q <= '0;
      perf_lu_q     <= '0;
      perf_flush_q  <= '0;
    end else begin
      perf_dstall_q <= perf_dstall_d;
      perf_lu_q     <= perf_lu_d;
      perf_flush_q  <= perf_flush_d;
    end
  end

  assign perf_dstall = perf_dstall_q;
  assign perf_lu     = perf_lu_q;
  assign perf_flush  = perf_flush_q;
`else
  logic unused_events;
  assign unused_events = lu_event ^ redir_event;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : table-driven scoreboard bench for pipe_ctrl (TIMEOUT_CYC=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst, acki_n, ackd_n, mem_req;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic       pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
  logic       exmem_we, memwb_we, memwb_flush, dwait, bus_err;

  int errors = 0;
  int checks = 0;

  // {pc_we ifid_we ifid_flush idex_we idex_flush exmem_we memwb_we memwb_flush dwait bus_err}
  localparam logic [9:0] RSTV    = 10'b0010100100;
  localparam logic [9:0] RST_ERR = 10'b0010100101;
  localparam logic [9:0] NORM    = 10'b1101011000;
  localparam logic [9:0] NORM_DW = 10'b1101011010;
  localparam logic [9:0] DST     = 10'b0000000100;
  localparam logic [9:0] DST_DW  = 10'b0000000110;
  localparam logic [9:0] LU      = 10'b0001111000;
  localparam logic [9:0] REDIR   = 10'b1111111000;
  localparam logic [9:0] IW      = 10'b0111011000;
  localparam logic [9:0] ERRV    = 10'b0000000001;

  // {rst acki_n ackd_n mem_req ex_mem_read ex_redirect use_rs1 use_rs2, rs1, rs2, rd}
  typedef logic [22:0] stim_t;

  logic [9:0] sb[$];

  pipe_ctrl #(.TIMEOUT_CYC(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .acki_n(acki_n), .ackd_n(ackd_n), .mem_req(mem_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
    .idex_flush(idex_flush), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .memwb_flush(memwb_flush), .dwait(dwait), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
            exmem_we, memwb_we, memwb_flush, dwait, bus_err};
  endfunction

  task automatic apply(input stim_t s);
    {rst, acki_n, ackd_n, mem_req, ex_mem_read, ex_redirect,
     id_use_rs1, id_use_rs2, id_rs1, id_rs2, ex_rd} = s;
  endtask

  task automatic test_reset();
    stim_t      st [3] = '{{8'b0110_0000, 15'd0}, {8'b0110_0000, 15'd0}, {8'b1110_0000, 15'd0}};
    logic [9:0] ev [3] = '{RSTV, RSTV, NORM};
    logic [9:0] exp_v;
    apply(st[0]);
    @(posedge clk); #1;
    foreach (ev[i]) sb.push_back(ev[i]);
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      #3;
      exp_v = sb.pop_front();
      checks++;
      if (outs() !== exp_v) begin
        errors++;
        $display("FAIL reset[%0d] got=%b exp=%b", i, outs(), exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_data_wait();
    stim_t st [8] = '{
      {8'b1101_0000, 5'd1, 5'd5, 5'd5},   // stall enters wait
      {8'b1101_1101, 5'd1, 5'd5, 5'd5},   // redirect + load-use ignored while stalled
      {8'b1001_0000, 5'd1, 5'd5, 5'd5},   // instruction wait ignored while stalled
      {8'b1111_0000, 5'd1, 5'd5, 5'd5},   // ack: advance, still DWAIT this cycle
      {8'b1110_0000, 5'd1, 5'd5, 5'd5},
      {8'b1101_0000, 5'd1, 5'd5, 5'd5},
      {8'b1100_0000, 5'd1, 5'd5, 5'd5},   // mem_req drops in DWAIT
      {8'b1110_0000, 5'd1, 5'd5, 5'd5}};
    logic [9:0] ev [8] = '{DST, DST_DW, DST_DW, NORM_DW, NORM, DST, NORM_DW, NORM};
    logic [9:0] exp_v;
    foreach (ev[i]) sb.push_back(ev[i]);
    for (int i = 0; i < 8; i++) begin
      apply(st[i]);
      #3;
      exp_v = sb.pop_front();
      checks++;
      if (outs() !== exp_v) begin
        errors++;
        $display("FAIL data_wait[%0d] got=%b exp=%b", i, outs(), exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t st [7] = '{
      {8'b1110_1001, 5'd7, 5'd5, 5'd5},   // rs2 hazard
      {8'b1110_0000, 5'd7, 5'd5, 5'd5},   // load moved on: single bubble
      {8'b1110_1000, 5'd7, 5'd5, 5'd5},   // match but rs2 unused
      {8'b1010_1001, 5'd7, 5'd5, 5'd5},   // hazard with instruction wait
      {8'b1110_1011, 5'd0, 5'd0, 5'd0},   // x0 never hazards
      {8'b1110_1010, 5'd7, 5'd5, 5'd7},   // rs1 hazard
      {8'b1110_0000, 5'd7, 5'd5, 5'd7}};
    logic [9:0] ev [7] = '{LU, NORM, NORM, LU, NORM, LU, NORM};
    logic [9:0] exp_v;
    foreach (ev[i]) sb.push_back(ev[i]);
    for (int i = 0; i < 7; i++) begin
      apply(st[i]);
      #3;
      exp_v = sb.pop_front();
      checks++;
      if (outs() !== exp_v) begin
        errors++;
        $display("FAIL load_use[%0d] got=%b exp=%b", i, outs(), exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_hazard();
    stim_t st [3] = '{
      {8'b1110_1101, 5'd7, 5'd5, 5'd5},   // redirect beats load-use
      {8'b1010_0100, 5'd7, 5'd5, 5'd5},   // redirect beats instruction wait
      {8'b1110_0000, 5'd7, 5'd5, 5'd5}};
    logic [9:0] ev [3] = '{REDIR, REDIR, NORM};
    logic [9:0] exp_v;
    foreach (ev[i]) sb.push_back(ev[i]);
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      #3;
      exp_v = sb.pop_front();
      checks++;
      if (outs() !== exp_v) begin
        errors++;
        $display("FAIL redirect[%0d] got=%b exp=%b", i, outs(), exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_instr_wait();
    stim_t st [3] = '{{8'b1010_0000, 15'd0}, {8'b1010_0000, 15'd0}, {8'b1110_0000, 15'd0}};
    logic [9:0] ev [3] = '{IW, IW, NORM};
    logic [9:0] exp_v;
    foreach (ev[i]) sb.push_back(ev[i]);
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      #3;
      exp_v = sb.pop_front();
      checks++;
      if (outs() !== exp_v) begin
        errors++;
        $display("FAIL instr_wait[%0d] got=%b exp=%b", i, outs(), exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    stim_t st [10] = '{
      {8'b1101_0000, 15'd0}, {8'b1101_0000, 15'd0}, {8'b1101_0000, 15'd0},
      {8'b1101_0000, 15'd0}, {8'b1101_0000, 15'd0},
      {8'b1101_0000, 15'd0},   // first cycle in ERR
      {8'b1110_0000, 15'd0},   // ack does not leave ERR
      {8'b0110_0000, 15'd0},   // rst low before the edge: bus_err still set
      {8'b0110_0000, 15'd0},
      {8'b1110_0000, 15'd0}};
    logic [9:0] ev [10] = '{DST, DST_DW, DST_DW, DST_DW, DST_DW,
                            ERRV, ERRV, RST_ERR, RSTV, NORM};
    logic [9:0] exp_v;
    foreach (ev[i]) sb.push_back(ev[i]);
    for (int i = 0; i < 10; i++) begin
      apply(st[i]);
      #3;
      exp_v = sb.pop_front();
      checks++;
      if (outs() !== exp_v) begin
        errors++;
        $display("FAIL timeout[%0d] got=%b exp=%b", i, outs(), exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_data_wait();
    test_load_use();
    test_redirect_hazard();
    test_instr_wait();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
